// File: rtl/color_scan_scheduler_if.sv
// Request/report, camera, recogniser and frame-RAM signals of the colour scan scheduler.
// The slave modport is the scheduler; master is everything around it.
interface color_scan_scheduler_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  // consumer handshake
  logic              i_request;
  logic              i_ack;
  logic              o_busy;
  logic              o_valid;
  logic              o_error;
  logic [7:0]        o_color;
  logic [ADDR_W-1:0] o_frame_bytes;
  // camera capture path
  logic              i_cam_vsync;
  logic              i_cam_we;
  logic [ADDR_W-1:0] i_cam_addr;
  logic [DATA_W-1:0] i_cam_data;
  // colour recogniser
  logic              o_rec_enable;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_done;
  logic [7:0]        i_rec_color;
  // shared frame-RAM port
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;

  modport master (
    output i_request, i_ack,
    output i_cam_vsync, i_cam_we, i_cam_addr, i_cam_data,
    output i_rec_addr, i_rec_done, i_rec_color,
    input  o_busy, o_valid, o_error, o_color, o_frame_bytes,
    input  o_rec_enable, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport slave (
    input  i_request, i_ack,
    input  i_cam_vsync, i_cam_we, i_cam_addr, i_cam_data,
    input  i_rec_addr, i_rec_done, i_rec_color,
    output o_busy, o_valid, o_error, o_color, o_frame_bytes,
    output o_rec_enable, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/color_scan_scheduler.sv
// One-shot colour measurement sequencer: arm on request, capture a frame into the
// frame RAM, run the recogniser over it, and hold the result until acknowledged.
module color_scan_scheduler #(
  parameter int          ADDR_W          = 15,
  parameter int          DATA_W          = 8,
  parameter int          BYTES_PER_FRAME = 19200,
  parameter int          TIMEOUT_CYC     = 2000000,
  parameter logic [7:0]  ERR_COLOR       = 8'hF0
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  color_scan_scheduler_if.slave bus
);

  localparam int                WD_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] FRAME_LEN = ADDR_W'(BYTES_PER_FRAME);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, SCAN, REPORT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] byte_cnt;
  logic [WD_W-1:0]   wdog;
  logic [1:0]        scan_age;
  logic              busy_q, valid_q, error_q, rec_en_q;
  logic [7:0]        color_q;

  logic active, timeout, cam_fwd, frame_done, rec_ready;

  assign active  = (state == ARM) || (state == CAPTURE) || (state == SCAN);
  assign timeout = active && (wdog >= WD_LAST);

  // A write landing on the watchdog's final cycle is dropped along with the frame.
  assign cam_fwd    = (state == CAPTURE) && bus.i_cam_we &&
                      (bus.i_cam_addr < FRAME_LEN) && !timeout;
  assign frame_done = cam_fwd && (byte_cnt == LAST_BYTE);

  // done may be left over from the previous run for the first two SCAN cycles
  assign rec_ready  = (scan_age == 2'd2) && bus.i_rec_done;

  assign bus.o_busy        = busy_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_error       = error_q;
  assign bus.o_color       = color_q;
  assign bus.o_rec_enable  = rec_en_q;
  assign bus.o_frame_bytes = FRAME_LEN;

  // Frame-RAM port ownership follows the state directly.
  always_comb begin
    bus.o_ram_we    = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wdata = '0;
    case (state)
      CAPTURE: begin
        bus.o_ram_we    = cam_fwd;
        bus.o_ram_addr  = bus.i_cam_addr;
        bus.o_ram_wdata = bus.i_cam_data;
      end
      SCAN:    bus.o_ram_addr = bus.i_rec_addr;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      wdog     <= '0;
      scan_age <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      rec_en_q <= 1'b0;
      color_q  <= '0;
    end else begin
      if (state == IDLE)
        wdog <= '0;
      else if (active && wdog != WD_MAX)
        wdog <= wdog + WD_W'(1);

      if (timeout) begin
        state    <= REPORT;
        color_q  <= ERR_COLOR;
        error_q  <= 1'b1;
        rec_en_q <= 1'b0;
        valid_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.i_request) begin
            state  <= ARM;
            busy_q <= 1'b1;
          end
          ARM: if (bus.i_cam_vsync) begin
            state    <= CAPTURE;
            byte_cnt <= '0;
          end
          CAPTURE: begin
            if (frame_done) begin
              state    <= SCAN;
              byte_cnt <= byte_cnt + ADDR_W'(1);
              rec_en_q <= 1'b1;
              scan_age <= '0;
            end else if (bus.i_cam_vsync) begin
              byte_cnt <= '0;
            end else if (cam_fwd) begin
              byte_cnt <= byte_cnt + ADDR_W'(1);
            end
          end
          SCAN: begin
            if (rec_ready) begin
              state    <= REPORT;
              color_q  <= bus.i_rec_color;
              error_q  <= 1'b0;
              rec_en_q <= 1'b0;
              valid_q  <= 1'b1;
            end else if (scan_age != 2'd2) begin
              scan_age <= scan_age + 2'd1;
            end
          end
          REPORT: if (bus.i_ack) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_scan_scheduler.sv
// Bench for color_scan_scheduler: table of measurement scenarios, random scenarios
// against an arithmetic timing model, and hand-written reset / overlap sequences.
module tb_color_scan_scheduler;
  localparam int         ADDR_W = 15;
  localparam int         DATA_W = 8;
  localparam int         BPF    = 8;
  localparam int         TO     = 50;
  localparam logic [7:0] ERR    = 8'hF0;
  localparam int         NEVER  = 999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  color_scan_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  color_scan_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTES_PER_FRAME(BPF),
    .TIMEOUT_CYC(TO), .ERR_COLOR(ERR)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         arm_wait, gap, short_len, rec_delay;
    bit         oor, no_vsync, rec_never, stale, vs_last;
    logic [7:0] color;
  } scn_t;

  typedef struct {
    scn_t       s;
    int         kf, at;
    logic [7:0] col;
    bit         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_cam_vsync = 1'b0;
    bus.i_cam_we    = 1'b0;
    bus.i_cam_addr  = '0;
    bus.i_cam_data  = '0;
    bus.i_rec_addr  = '0;
    bus.i_rec_done  = 1'b0;
    bus.i_rec_color = '0;
  endtask

  function automatic scn_t mk(input int arm_wait, gap, short_len, rec_delay,
                              input bit oor, no_vsync, rec_never, stale, vs_last,
                              input logic [7:0] color);
    scn_t s;
    s.arm_wait = arm_wait; s.gap = gap; s.short_len = short_len; s.rec_delay = rec_delay;
    s.oor = oor; s.no_vsync = no_vsync; s.rec_never = rec_never; s.stale = stale;
    s.vs_last = vs_last; s.color = color;
    return s;
  endfunction

  // Cycle numbers count edges after the request edge. Frame ends at kf; the
  // recogniser result is usable no earlier than 3 cycles into SCAN; the watchdog
  // ends the run at TO, winning ties.
  function automatic void predict(input scn_t s, output int kf, output int at,
                                  output logic [7:0] col, output bit err);
    int p;
    int nat;
    p  = 1 + s.gap;
    kf = s.no_vsync ? NEVER
       : 1 + s.arm_wait + (s.short_len > 0 ? s.short_len * p + 1 : 0) + (BPF + int'(s.oor)) * p;
    nat = (s.no_vsync || s.rec_never) ? NEVER : kf + (s.rec_delay > 3 ? s.rec_delay : 3);
    if (nat < TO) begin at = nat; col = s.color; err = 1'b0; end
    else          begin at = TO;  col = ERR;     err = 1'b1; end
  endfunction

  // Plays one measurement up to REPORT; the recogniser reacts to o_rec_enable.
  task automatic measure(input scn_t s, input bit pre_armed, input int kf, input int at,
                         input logic [7:0] col, input bit err, input string tag);
    bit                vs[256];
    bit                we[256];
    logic [ADDR_W-1:0] ad[256];
    logic [7:0]        dt[256];
    int kv, k, idx, en_cnt, got_at;
    bit exp_we, exp_en, real_done;
    foreach (vs[i]) begin vs[i] = 1'b0; we[i] = 1'b0; ad[i] = '0; dt[i] = '0; end
    kv = s.no_vsync ? NEVER : 1 + s.arm_wait;
    if (s.arm_wait > 0 || s.no_vsync) begin we[1] = 1'b1; dt[1] = 8'hA5; end
    if (!s.no_vsync) begin
      vs[kv] = 1'b1;
      k = kv;
      for (int j = 0; j < s.short_len; j++) begin
        k += 1 + s.gap; we[k] = 1'b1; ad[k] = ADDR_W'(j); dt[k] = 8'($urandom);
      end
      if (s.short_len > 0) begin k++; vs[k] = 1'b1; end
      idx = 0;
      for (int j = 0; j < BPF + int'(s.oor); j++) begin
        k += 1 + s.gap; we[k] = 1'b1; dt[k] = 8'($urandom);
        if (s.oor && j == 4) ad[k] = ADDR_W'(BPF + int'($urandom_range(0, 200)));
        else begin ad[k] = ADDR_W'(idx); idx++; end
      end
      if (s.vs_last) vs[k] = 1'b1;
    end

    if (!pre_armed) begin bus.i_request = 1'b1; step(); bus.i_request = 1'b0; end
    en_cnt = 0;
    got_at = -1;
    for (int c = 1; c <= at + 5 && c < 256; c++) begin
      if (bus.o_rec_enable) en_cnt++;
      bus.i_cam_vsync = vs[c];
      bus.i_cam_we    = we[c];
      bus.i_cam_addr  = ad[c];
      bus.i_cam_data  = dt[c];
      bus.i_rec_addr  = ADDR_W'($urandom);
      real_done       = en_cnt > 0 && !s.rec_never && en_cnt >= s.rec_delay;
      bus.i_rec_done  = real_done || (s.stale && en_cnt >= 1 && en_cnt <= 2);
      bus.i_rec_color = real_done ? s.color : 8'($urandom);
      @(negedge clk);
      if (c <= at) begin
        exp_we = we[c] && (ad[c] < ADDR_W'(BPF)) && c > kv && c <= kf && c < TO;
        check({tag, "/ram_we"}, 32'(bus.o_ram_we), 32'(exp_we));
        if (exp_we) begin
          check({tag, "/ram_addr"}, 32'(bus.o_ram_addr), 32'(ad[c]));
          check({tag, "/ram_wdata"}, 32'(bus.o_ram_wdata), 32'(dt[c]));
        end
        exp_en = c > kf && kf < TO;
        check({tag, "/rec_en"}, 32'(bus.o_rec_enable), 32'(exp_en));
        if (exp_en) check({tag, "/scan_addr"}, 32'(bus.o_ram_addr), 32'(bus.i_rec_addr));
      end
      @(posedge clk);
      #1;
      if (bus.o_valid) begin got_at = c; break; end
    end
    idle_inputs();
    check({tag, "/valid_at"}, 32'(got_at), 32'(at));
    check({tag, "/color"}, 32'(bus.o_color), 32'(col));
    check({tag, "/error"}, 32'(bus.o_error), 32'(err));
    check({tag, "/rec_en_rep"}, 32'(bus.o_rec_enable), 32'(0));
    check({tag, "/busy_rep"}, 32'(bus.o_busy), 32'(1));
    repeat (2) begin
      bus.i_rec_done = 1'b1; bus.i_rec_color = 8'($urandom);
      step();
    end
    idle_inputs();
    check({tag, "/color_hold"}, 32'(bus.o_color), 32'(col));
    check({tag, "/valid_hold"}, 32'(bus.o_valid), 32'(1));
  endtask

  task automatic ack_and_check(input string tag);
    bus.i_ack = 1'b1;
    step();
    bus.i_ack = 1'b0;
    check({tag, "/valid_ack"}, 32'(bus.o_valid), 32'(0));
    check({tag, "/busy_ack"}, 32'(bus.o_busy), 32'(0));
    step();
    check({tag, "/busy_idle"}, 32'(bus.o_busy), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    vec_t tbl[10];
    scn_t s;
    int   kf, at;
    logic [7:0] col;
    bit   err;

    idle_inputs();
    bus.i_request = 1'b0;
    bus.i_ack     = 1'b0;

    // reset state, no clock edge yet
    #2;
    check("rst/busy", 32'(bus.o_busy), 32'(0));
    check("rst/valid", 32'(bus.o_valid), 32'(0));
    check("rst/error", 32'(bus.o_error), 32'(0));
    check("rst/color", 32'(bus.o_color), 32'(0));
    check("rst/rec_en", 32'(bus.o_rec_enable), 32'(0));
    check("rst/ram_we", 32'(bus.o_ram_we), 32'(0));
    check("rst/ram_addr", 32'(bus.o_ram_addr), 32'(0));
    check("rst/frame_bytes", 32'(bus.o_frame_bytes), 32'(BPF));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    //            arm gap shr rd   oor nov nev stl vsl col       kf     at  col  err
    tbl[0] = '{mk(0, 0, 0, 10,  0, 0, 0, 0, 0, 8'd2),  9,     19, 8'd2, 1'b0};
    tbl[1] = '{mk(2, 0, 5, 3,   0, 0, 0, 0, 1, 8'd1),  17,    20, 8'd1, 1'b0};
    tbl[2] = '{mk(1, 1, 0, 4,   1, 0, 0, 0, 0, 8'd3),  20,    24, 8'd3, 1'b0};
    tbl[3] = '{mk(3, 0, 0, 5,   0, 1, 0, 0, 0, 8'd2),  NEVER, 50, ERR,  1'b1};
    tbl[4] = '{mk(0, 0, 0, 5,   0, 0, 1, 0, 0, 8'd1),  9,     50, ERR,  1'b1};
    tbl[5] = '{mk(0, 0, 0, 5,   0, 0, 0, 1, 0, 8'd1),  9,     14, 8'd1, 1'b0};
    tbl[6] = '{mk(0, 0, 0, 41,  0, 0, 0, 0, 0, 8'd2),  9,     50, ERR,  1'b1};
    tbl[7] = '{mk(0, 0, 0, 40,  0, 0, 0, 0, 0, 8'd2),  9,     49, 8'd2, 1'b0};
    tbl[8] = '{mk(0, 2, 7, 5,   1, 0, 0, 0, 0, 8'd3),  50,    50, ERR,  1'b1};
    tbl[9] = '{mk(0, 0, 0, 1,   0, 0, 0, 0, 0, 8'd3),  9,     12, 8'd3, 1'b0};

    for (int i = 0; i < 10; i++) begin
      measure(tbl[i].s, 1'b0, tbl[i].kf, tbl[i].at, tbl[i].col, tbl[i].err, $sformatf("tbl%0d", i));
      ack_and_check($sformatf("tbl%0d", i));
    end

    // request held through ack: one IDLE cycle, then a new run with stale done
    measure(tbl[0].s, 1'b0, tbl[0].kf, tbl[0].at, tbl[0].col, tbl[0].err, "ovl_a");
    bus.i_request = 1'b1;
    step();
    check("ovl/req_ignored", 32'(bus.o_valid), 32'(1));
    bus.i_ack = 1'b1;
    step();
    bus.i_ack = 1'b0;
    check("ovl/busy_drop", 32'(bus.o_busy), 32'(0));
    check("ovl/valid_drop", 32'(bus.o_valid), 32'(0));
    step();
    check("ovl/busy_rearm", 32'(bus.o_busy), 32'(1));
    bus.i_request = 1'b0;
    measure(tbl[5].s, 1'b1, tbl[5].kf, tbl[5].at, tbl[5].col, tbl[5].err, "ovl_b");
    ack_and_check("ovl_b");

    // asynchronous reset while scanning
    bus.i_request = 1'b1; step(); bus.i_request = 1'b0;
    bus.i_cam_vsync = 1'b1; step(); bus.i_cam_vsync = 1'b0;
    for (int j = 0; j < BPF; j++) begin
      bus.i_cam_we = 1'b1; bus.i_cam_addr = ADDR_W'(j); bus.i_cam_data = 8'($urandom);
      step();
    end
    idle_inputs();
    step();
    check("rstscan/rec_en_pre", 32'(bus.o_rec_enable), 32'(1));
    check("rstscan/busy_pre", 32'(bus.o_busy), 32'(1));
    bus.i_cam_we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rstscan/rec_en", 32'(bus.o_rec_enable), 32'(0));
    check("rstscan/busy", 32'(bus.o_busy), 32'(0));
    check("rstscan/ram_we", 32'(bus.o_ram_we), 32'(0));
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    measure(tbl[0].s, 1'b0, tbl[0].kf, tbl[0].at, tbl[0].col, tbl[0].err, "post_rst");
    ack_and_check("post_rst");

    // random scenarios against the timing model
    for (int i = 0; i < 24; i++) begin
      s = mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, BPF - 1)),
             int'($urandom_range(1, 40)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      predict(s, kf, at, col, err);
      measure(s, 1'b0, kf, at, col, err, $sformatf("rnd%0d", i));
      ack_and_check($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
